// File: rtl/except_pipe_pkg.sv
// rtl/except_pipe_pkg.sv - exception pack type, FSM states and empty pack constant
package except_pipe_pkg;

  typedef struct packed {
    logic        except;
    logic [63:0] epc;
    logic [63:0] ecause;
    logic [63:0] etval;
  } except_pack_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } except_state_t;

  localparam except_pack_t EXCEPT_NONE = '0;

endpackage

// File: rtl/except_pipe_if.sv
// rtl/except_pipe_if.sv - trap handshake between the exception pipe and the CSR unit
interface except_pipe_if;
  import except_pipe_pkg::*;

  logic         trap_valid_o;
  logic         trap_ready_i;
  except_pack_t trap_o;

  modport master (output trap_valid_o, output trap_o, input trap_ready_i);
  modport slave  (input trap_valid_o, input trap_o, output trap_ready_i);

endinterface

// File: rtl/except_pipe_stage.sv
// rtl/except_pipe_stage.sv - one boundary register with oldest-wins merge and rst/flush/hold priority
module except_stage
  import except_pipe_pkg::*;
#(
  parameter bit FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         hold,
  input  except_pack_t prev,
  input  except_pack_t inj,
  output except_pack_t r
);

  except_pack_t m;

  // An exception already travelling from the older stage beats a newly detected one.
  always_comb begin
    m = prev;
    if (FIRST) begin
      m = inj;
    end else if (prev.except) begin
      m = prev;
    end else if (inj.except) begin
      m = inj;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= EXCEPT_NONE;
    end else if (flush) begin
      r <= EXCEPT_NONE;
    end else if (hold || stall) begin
      r <= r;
    end else begin
      r <= m;
    end
  end

endmodule

// File: rtl/except_pipe.sv
// rtl/except_pipe.sv - exception tracking across all pipeline boundaries with trap handshake and global flush
module except_pipe
  import except_pipe_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  input  except_pack_t [STAGES-1:0] inj_i,
  except_pipe_if.master             trap_bus,
  output logic                      stall_req_o,
  output logic                      flush_req_o,
  output logic [STAGES-1:0]         except_vec_o,
  output logic [CNT_W-1:0]          trap_count_o
);

  except_state_t state, state_next;
  except_pack_t  r    [STAGES];
  except_pack_t  prev [STAGES];
  logic          hold;
  logic          commit_except;
  logic          trap_valid;
  logic          cnt_inc;

  assign commit_except = r[STAGES-1].except;
  assign hold          = (state != IDLE) || commit_except;
  assign trap_valid    = (state == WAIT) && commit_except;
  assign flush_req_o   = (state == FLUSH);
  assign stall_req_o   = hold;

  assign trap_bus.trap_valid_o = trap_valid;
  assign trap_bus.trap_o       = r[STAGES-1];

  assign prev[0] = EXCEPT_NONE;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign prev[k] = r[k-1];
    end

    except_stage #(
      .FIRST (k == 0)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .stall (stall[k]),
      .flush (flush[k] || flush_req_o),
      .hold  (hold),
      .prev  (prev[k]),
      .inj   (inj_i[k]),
      .r     (r[k])
    );

    assign except_vec_o[k] = r[k].except;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake wins over a same-cycle commit flush; otherwise a cleared commit aborts the trap.
  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit_except) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (trap_valid && trap_bus.trap_ready_i) begin
          state_next = FLUSH;
          cnt_inc    = 1'b1;
        end else if (flush[STAGES-1] || !commit_except) begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_count_o <= '0;
    end else if (cnt_inc) begin
      trap_count_o <= trap_count_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/except_pipe.md
Name: except_pipe

Overview:
- Parametrised exception-tracking pipeline. Replaces the per-stage single exception registers with one block covering all STAGES pipeline boundaries.
- Carries an ExceptPack alongside each in-flight instruction and merges newly detected exceptions at each boundary, with the oldest exception winning.
- Presents the commit-stage exception to the CSR/trap unit through a valid/ready handshake. Freezes the pipe while the trap is pending, then issues a global flush.
- Sits between the pipeline datapath and the CSR unit.

Parameters:
- STAGES, 4, number of boundary registers (index 0 = IF/ID, STAGES-1 = commit/MEM-WB); legal range 2..8.
- CNT_W, 16, width of the accepted-trap counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- stall, input, STAGES, per-boundary hold from the hazard unit.
- flush, input, STAGES, per-boundary clear from the hazard/branch unit.
- inj_i, input, STAGES x ExceptPack, exception detected in the stage feeding boundary k.
- trap_ready_i, input, 1, CSR unit accepts the trap.
- trap_valid_o, output, 1, commit-stage exception offered.
- trap_o, output, ExceptPack, commit-stage exception payload (r[STAGES-1]).
- stall_req_o, output, 1, asks the hazard unit to freeze the whole pipe.
- flush_req_o, output, 1, one-cycle global flush after acceptance.
- except_vec_o, output, STAGES, bit k = r[k].except.
- trap_count_o, output, CNT_W, number of accepted traps.

Behaviour:
- Merge input per boundary:
  - m[0] = inj_i[0].
  - For k>0: m[k] = r[k-1] if r[k-1].except, else inj_i[k] if inj_i[k].except, else r[k-1].
- Register update per k, in priority order:
  - rst -> all fields 0.
  - Else flush[k] or flush_req_o -> 0.
  - Else hold or stall[k] -> keep.
  - Else r[k] <= m[k].
- hold (combinational) = (state != IDLE) | r[STAGES-1].except. stall_req_o = hold.
- FSM states: IDLE, WAIT, FLUSH. Reset -> IDLE.
  - IDLE: if r[STAGES-1].except -> WAIT.
  - WAIT: trap_valid_o = r[STAGES-1].except, combinational.
    - trap_valid_o & trap_ready_i -> FLUSH, and trap_count_o increments by 1, wrapping at 2^CNT_W.
    - If flush[STAGES-1] clears the commit register while in WAIT, the trap is aborted: trap_valid_o drops the next cycle, FSM -> IDLE, no count.
  - FLUSH: flush_req_o = 1 for exactly one cycle; every register is cleared at that edge; -> IDLE.
- Latency:
  - Exception injected at boundary k with no stalls reaches commit after STAGES-k edges.
  - trap_valid_o rises one cycle after commit capture (IDLE->WAIT edge).
  - flush_req_o is asserted the cycle after the handshake.
- trap_valid_o is low outside WAIT. ready without valid has no effect.
- A younger exception behind a pending trap stays frozen by hold and is discarded by the global flush.
- Simultaneous inj_i[k] and an older r[k-1].except: the older one is kept, payload untouched.
- rst in any state: FSM -> IDLE, all outputs 0 the next cycle, including trap_count_o.
- Reset values of all outputs: 0.

Decomposition:
- ExceptStruct package keeps ExceptPack: except 1, epc 64, ecause 64, etval 64.
- Add to the package:
  - typedef except_state_t {IDLE, WAIT, FLUSH}.
  - constant EXCEPT_NONE (all-zero pack).
- One sub-module, except_stage: a single boundary register with merge mux, stall/flush/hold priority, and rst. It is instantiated STAGES times by a generate loop.
- The FSM and counter stay in the top.

Test Plan:
- Basic propagation, STAGES=4, no stalls: inj_i[1] = {1, epc 0x80000010, ecause 2, etval 0xDEAD}.
  - except_vec_o walks bit 1->2->3.
  - trap_valid_o rises 1 cycle after bit 3 sets.
  - trap_o matches the payload exactly.
- Priority:
  - Same cycle, r[1] holds cause 2 and inj_i[2] = cause 5 -> r[2] takes cause 2.
  - With r[1] clean -> r[2] takes cause 5.
- Handshake:
  - Hold trap_ready_i low 5 cycles -> trap_valid_o and stall_req_o stay 1, and all r[k] stay frozen even with stall=0.
  - Raise ready -> flush_req_o high one cycle, except_vec_o = 0 next cycle, trap_count_o 0->1.
- Abort: assert flush[3] while in WAIT -> trap_valid_o drops the next cycle, FSM IDLE, trap_count_o unchanged.
- Reset mid-WAIT: assert rst -> next cycle all outputs 0, including trap_count_o; a new injection afterwards propagates normally.
- Counter wrap: CNT_W=2, accept 5 traps -> trap_count_o = 1.
